// File: rtl/shift_pkg.sv
// Shared encodings for the multicycle shift unit: op codes, amount sources and FSM states.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        AMT_SHAMT = 2'b00,
        AMT_REG   = 2'b01,
        AMT_16    = 2'b10,
        AMT_ZERO  = 2'b11
    } amt_sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int CONST_AMT_16 = 16;

endpackage

// File: rtl/shift_amt_mux.sv
// Combinational 4:1 shift-amount select; every source is brought to AMT_W bits.
module shift_amt_mux
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic [1:0]       amt_sel,
    input  logic [AMT_W-1:0] shamt_field,
    input  logic [WIDTH-1:0] amt_reg,
    output logic [AMT_W-1:0] amt
);

    // Upper register bits are dropped on purpose (sllv-style modulo amount).
    logic unused_amt_reg_hi;
    assign unused_amt_reg_hi = ^amt_reg[WIDTH-1:AMT_W];

    always_comb begin
        amt = '0;
        case (amt_sel_t'(amt_sel))
            AMT_SHAMT: amt = shamt_field;
            AMT_REG:   amt = amt_reg[AMT_W-1:0];
            AMT_16:    amt = AMT_W'(CONST_AMT_16);
            AMT_ZERO:  amt = '0;
            default:   amt = '0;
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Multicycle shifter: captures operand/op/amount on start, shifts STEP bits per cycle.
// Optional rotate-right for op=11 when SHIFT_UNIT_ROTATE_EN is defined.
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 1,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [1:0]       amt_sel,
    input  logic [AMT_W-1:0] shamt_field,
    input  logic [WIDTH-1:0] amt_reg,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_t           state;
    shift_op_t        op_q;
    logic [AMT_W-1:0] remaining;
    logic [AMT_W-1:0] amt_mux;
    logic [AMT_W-1:0] amt_eff;
    logic [AMT_W-1:0] stp;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] shifted;

    shift_amt_mux #(.WIDTH(WIDTH)) u_amt_mux (
        .amt_sel     (amt_sel),
        .shamt_field (shamt_field),
        .amt_reg     (amt_reg),
        .amt         (amt_mux)
    );

`ifdef SHIFT_UNIT_ROTATE_EN
    assign amt_eff = amt_mux;
`else
    // Without rotate, op=11 degenerates to a zero-length pass-through.
    assign amt_eff = (shift_op_t'(op) == OP_ROR) ? '0 : amt_mux;
`endif

    assign stp = (remaining < AMT_W'(STEP)) ? remaining : AMT_W'(STEP);

`ifdef SHIFT_UNIT_ROTATE_EN
    logic [2*WIDTH-1:0] dbl;
    assign dbl = {work, work} >> stp;
`endif

    always_comb begin
        shifted = work;
        case (op_q)
            OP_SLL:  shifted = work << stp;
            OP_SRL:  shifted = work >> stp;
            OP_SRA:  shifted = WIDTH'($signed(work) >>> stp);
`ifdef SHIFT_UNIT_ROTATE_EN
            OP_ROR:  shifted = dbl[WIDTH-1:0];
`endif
            default: shifted = work;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= OP_SLL;
            remaining <= '0;
            work      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    // A start that lines up with the trailing done pulse is dropped.
                    if (start && !done) begin
                        work      <= data_in;
                        op_q      <= shift_op_t'(op);
                        remaining <= amt_eff;
                        if (amt_eff == '0) begin
                            state <= DONE;
                        end else begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    work      <= shifted;
                    remaining <= remaining - stp;
                    if (remaining == stp) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    result <= work;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
